// File: rtl/interleaver_prime_stream.sv
// interleaver_prime_stream: ping-pong frame interleaver using the incremental prime-step permutation.
module interleaver_prime_stream #(
  parameter int BITS = 8,
  parameter int N = 10,
  parameter int P = 3,
  parameter int TAIL_BITS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dir,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_first,
  output logic            out_last,
  output logic            busy
);
  localparam int L = N + TAIL_BITS;
  localparam int KW = $clog2(L) + 1;
  localparam int AW = $clog2(N) + 1;
  localparam int IW = $clog2(L);

  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  if (P < 1 || P >= N || gcd(P, N) != 1) begin : g_bad_params
    $error("interleaver_prime_stream: P must satisfy 1 <= P < N and gcd(P,N) == 1");
  end

  // Incremental (a + P) mod N; a < N and P < N so one conditional subtract suffices.
  function automatic logic [AW-1:0] step(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + AW'(P);
    return (s >= AW'(N)) ? s - AW'(N) : s;
  endfunction

  logic [BITS-1:0] mem [2][L];
  logic [1:0]      full, bdir;
  logic            wr_bank, rd_bank, rdy;
  logic [KW-1:0]   wk, rk;
  logic [AW-1:0]   wa, ra;
  logic [IW-1:0]   w_addr, r_addr;
  logic [BITS-1:0] rdata;
  logic            wd, push, adv, pop, wlast, rlast;

  always_comb begin
    wd = (wk == '0) ? dir : bdir[wr_bank];
    w_addr = (wk >= KW'(N) || !wd) ? IW'(wk) : IW'(wa);
    r_addr = (rk >= KW'(N) || bdir[rd_bank]) ? IW'(rk) : IW'(ra);
    rdata = mem[rd_bank][r_addr];
    in_ready = rdy && !full[wr_bank];
    push = in_valid && in_ready;
    adv = !out_valid || out_ready;
    pop = adv && full[rd_bank];
    wlast = wk == KW'(L - 1);
    rlast = rk == KW'(L - 1);
    busy = (|full) || (wk != '0) || out_valid;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_bank][w_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= 1'b0;
      full <= '0;
      bdir <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wk <= '0;
      wa <= '0;
      rk <= '0;
      ra <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (push) begin
        if (wk == '0) bdir[wr_bank] <= dir;
        wk <= wlast ? '0 : wk + 1'b1;
        wa <= wlast ? '0 : step(wa);
        if (wlast) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= !wr_bank;
        end
      end
      if (adv) out_valid <= full[rd_bank];
      if (pop) begin
        out_data <= rdata;
        out_first <= rk == '0;
        out_last <= rlast;
        rk <= rlast ? '0 : rk + 1'b1;
        ra <= rlast ? '0 : step(ra);
        if (rlast) begin
          full[rd_bank] <= 1'b0;
          rd_bank <= !rd_bank;
        end
      end
    end
  end
endmodule

// File: doc/interleaver_prime_stream.md
Name: interleaver_prime_stream

Overview:
- Streaming frame interleaver built around the prime-step permutation. Index i (i < N) maps to (P*i) mod N; tail indices i >= N pass through at their natural position.
- Accepts one word per cycle on a valid/ready input and stores each frame of L = N+TAIL_BITS words in one of two ping-pong banks. Emits the permuted frame on a valid/ready output.
- Sits between the encoder-side or decoder-side stages of the turbo chain. Per-frame `dir` selects forward (encoder, extrinsic) or reverse (de-interleave) permutation.
- Permuted addresses are generated incrementally, with no multiplier or divider.

Parameters:
- BITS, 8, word width.
- N, 10, permuted frame length.
- P, 3, prime step. Requires 1 <= P < N and gcd(P,N) == 1; elaboration raises $error otherwise.
- TAIL_BITS, 0, unpermuted trailing words per frame.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- dir, in, 1, 0 = forward (out[i]=in[(P*i)%N]), 1 = reverse (out[(P*i)%N]=in[i]). Sampled with the first word of each frame.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, block can accept a word.
- in_data, in, BITS, input word.
- out_valid, out, 1, output word valid.
- out_ready, in, 1, downstream accepts.
- out_data, out, BITS, output word.
- out_first, out, 1, high with output word index 0.
- out_last, out, 1, high with output word index L-1.
- busy, out, 1, any bank full or partially written, or the output register is valid.

Behaviour:
- Reset (async assert, sync deassert by the reset tree):
  - in_ready=0 while rst_n low and 1 from the first edge after release.
  - out_valid, out_first, out_last, busy = 0; out_data = 0.
  - Both banks are marked empty; wr_bank=0, rd_bank=0; all counters are 0.
- Storage: two banks of L words, register array, combinational read.
  - Each bank has a full flag and a latched dir bit.
- Address generator (one per side):
  - Index counter k runs 0..L-1.
  - Permuted address a starts at 0. Step: s = a+P; a_next = (s >= N) ? s-N : s. Width is $clog2(N)+1 bits.
  - For k >= N, address = k (tail).
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: write in_data to address W. W = k when dir=0; W = permuted address when dir=1. `dir` is latched into the bank at k=0; later dir changes in the frame are ignored.
  - At k = L-1: set full[wr_bank], toggle wr_bank, reset the counter and generator.
- Read side:
  - Output register advances when !out_valid || out_ready.
  - If it advances and full[rd_bank]: load the word at address R into the output register. R = permuted address when the bank dir=0; R = k when dir=1. Set out_valid, out_first=(k==0), out_last=(k==L-1).
  - After loading k = L-1: clear full[rd_bank], toggle rd_bank.
  - If it advances and the bank is not full: out_valid <= 0.
- Latency:
  - First output word is valid on the edge after the edge that accepted the last input word, i.e. L+1 edges after the first accept with no stall.
  - Sustained throughput is 1 word/cycle with back-to-back frames.
- Boundary rules:
  - Both banks full: in_ready=0. The bank freed by the read side becomes writable the cycle after its full flag clears (registered, no bypass).
  - A simultaneous final write to bank A and final read of bank B is legal; both flags update on the same edge.
  - out_data, out_first and out_last hold stable while out_valid && !out_ready.
  - Reset mid-frame discards all partial and complete frames; no output is produced for them.
  - TAIL_BITS=0: no tail path; L=N.

Test Plan:
- N=10, P=3, dir=0, input 0..9, out_ready=1 -> output 0,3,6,9,2,5,8,1,4,7; out_first on word 0, out_last on word 7 (last emitted); first out_valid 11 edges after first accept.
- Same config, dir=1, input 0..9 -> output 0,7,4,1,8,5,2,9,6,3. Feeding this output back through dir=0 returns 0..9.
- TAIL_BITS=2, dir=0, input 0..11 -> 0,3,6,9,2,5,8,1,4,7,10,11.
- Three back-to-back frames (dir 0,1,0), out_ready held low 25 cycles -> in_ready drops after 20 accepted words; after release, frames emerge in order, each correctly permuted, and out_data holds during the stall.
- Random in_valid/out_ready toggling, 100 frames, N=13, P=5 -> scoreboard matches the permutation model; no loss or duplication.
- rst_n pulsed low after 4 words of frame 2 -> outputs go to 0 immediately; the next frame 0..9 (dir=0) gives the first scenario's result exactly.
